// File: rtl/sprite_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sprite_pkg -- geometry, colour key and animation constants for sprite_fetch
// Rev 1.0
// ---------------------------------------------------------------------------
package sprite_pkg;
    localparam int W        = 32;
    localparam int H        = 32;
    localparam int FRAMES   = 3;
    localparam int ANIM_DIV = 6;
    localparam int ADDR_W   = 12;
    localparam int COL_W    = $clog2(W);
    localparam int ROW_W    = $clog2(H);
    localparam int DIV_W    = $clog2(ANIM_DIV);
    localparam logic [23:0] KEY = 24'hFF00FF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WALK = 1'b1
    } anim_state_t;
endpackage
`default_nettype wire

// File: rtl/sprite_anim_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sprite_anim_fsm -- frame-pulse edge detector and walk-cycle frame counter
// Rev 1.0
// ---------------------------------------------------------------------------
module sprite_anim_fsm
    import sprite_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       moving,
    output logic       frame_edge,
    output logic [1:0] frame_idx
);
    anim_state_t      state, state_n;
    logic             fc_d1, fc_d2;
    logic [1:0]       idx_n;
    logic [DIV_W-1:0] div_cnt, div_n;

    assign frame_edge = fc_d1 & ~fc_d2;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_d1     <= 1'b0;
            fc_d2     <= 1'b0;
            state     <= IDLE;
            frame_idx <= 2'd0;
            div_cnt   <= '0;
        end else begin
            fc_d1     <= frame_clk;
            fc_d2     <= fc_d1;
            state     <= state_n;
            frame_idx <= idx_n;
            div_cnt   <= div_n;
        end
    end

    // The entry edge into WALK does not count toward the divider.
    always_comb begin
        state_n = state;
        idx_n   = frame_idx;
        div_n   = div_cnt;
        if (frame_edge) begin
            case (state)
                IDLE: begin
                    idx_n = 2'd0;
                    div_n = '0;
                    if (moving)
                        state_n = WALK;
                end
                WALK: begin
                    if (!moving) begin
                        state_n = IDLE;
                        idx_n   = 2'd0;
                        div_n   = '0;
                    end else if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                        div_n = '0;
                        idx_n = (frame_idx == 2'(FRAMES - 1)) ? 2'd0 : frame_idx + 2'd1;
                    end else begin
                        div_n = div_cnt + DIV_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/sprite_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sprite_fetch -- sprite ROM address generator with 2-cycle pixel pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
module sprite_fetch
    import sprite_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              facing_left,
    input  logic              moving,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              sprite_on,
    output logic [23:0]       pic_out
);
    logic              frame_edge;
    logic [1:0]        frame_idx;
    logic [9:0]        lx, ly;
    logic              lface, lmove;
    logic              move_sel;
    logic              in_box, in_box_d1, in_box_d2;
    logic [COL_W-1:0]  col, col_m;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;

    // On the edge cycle the FSM sees the value being latched this cycle.
    assign move_sel = frame_edge ? moving : lmove;

    sprite_anim_fsm u_anim (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .moving     (move_sel),
        .frame_edge (frame_edge),
        .frame_idx  (frame_idx)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lx    <= 10'd0;
            ly    <= 10'd1023;
            lface <= 1'b0;
            lmove <= 1'b0;
        end else if (frame_edge) begin
            lx    <= sprite_x;
            ly    <= sprite_y;
            lface <= facing_left;
            lmove <= moving;
        end
    end

    // 11-bit compare so a box near 1023 cannot wrap back onto low coordinates.
    assign in_box = ({1'b0, DrawX} >= {1'b0, lx}) && ({1'b0, DrawX} < ({1'b0, lx} + 11'(W))) &&
                    ({1'b0, DrawY} >= {1'b0, ly}) && ({1'b0, DrawY} < ({1'b0, ly} + 11'(H)));

    assign col   = COL_W'(DrawX - lx);
    assign row   = ROW_W'(DrawY - ly);
    assign col_m = lface ? (COL_W'(W - 1) - col) : col;
    assign addr  = ADDR_W'(frame_idx) * ADDR_W'(W * H) + ADDR_W'(row) * ADDR_W'(W) + ADDR_W'(col_m);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr  <= '0;
            in_box_d1 <= 1'b0;
            in_box_d2 <= 1'b0;
        end else begin
            rom_addr  <= in_box ? addr : '0;
            in_box_d1 <= in_box;
            in_box_d2 <= in_box_d1;
        end
    end

    assign sprite_on = in_box_d2 && (rom_data != KEY);
    assign pic_out   = sprite_on ? rom_data : 24'h000000;
endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sprite_fetch -- directed-vector bench with a 1-cycle synchronous ROM model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sprite_fetch;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  DrawX = 10'd0, DrawY = 10'd0;
    logic [9:0]  sprite_x = 10'd0, sprite_y = 10'd0;
    logic        facing_left = 1'b0, moving = 1'b0;
    logic [11:0] rom_addr;
    logic [23:0] rom_data;
    logic        sprite_on;
    logic [23:0] pic_out;

    logic        force_en = 1'b0;
    logic [23:0] force_val = 24'h0;
    int          tests = 0;
    int          fails = 0;

    sprite_fetch dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .facing_left (facing_left),
        .moving      (moving),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sprite_on   (sprite_on),
        .pic_out     (pic_out)
    );

    initial forever #5 Clk = ~Clk;

    // ROM content: upper 12 bits A50, lower 12 bits = address (never equals the key).
    always @(posedge Clk)
        rom_data <= force_en ? force_val : {12'hA50, rom_addr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_pulse(input int x, input int y, input logic face, input logic mov);
        sprite_x    = 10'(x);
        sprite_y    = 10'(y);
        facing_left = face;
        moving      = mov;
        frame_clk   = 1'b1;
        step();
        step();
        frame_clk   = 1'b0;
        step();
        step();
    endtask

    task automatic pixel(input string tag, input int x, input int y,
                         input int exp_addr, input logic exp_on, input logic [23:0] exp_pic);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step();
        check({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
        step();
        check({tag, ".on"}, 32'(sprite_on), 32'(exp_on));
        check({tag, ".pic"}, 32'(pic_out), 32'(exp_pic));
    endtask

    initial begin
        int e;
        step();
        step();
        check("rst.on", 32'(sprite_on), 32'd0);
        check("rst.pic", 32'(pic_out), 32'd0);
        check("rst.addr", 32'(rom_addr), 32'd0);
        Reset = 1'b0;

        pixel("hidden", 5, 5, 0, 1'b0, 24'h0);

        frame_pulse(100, 200, 1'b0, 1'b0);
        pixel("origin", 100, 200, 0, 1'b1, 24'hA50000);
        pixel("r3c5", 105, 203, 101, 1'b1, 24'hA50065);
        pixel("left_out", 99, 200, 0, 1'b0, 24'h0);
        pixel("right_out", 132, 200, 0, 1'b0, 24'h0);
        pixel("below_out", 100, 232, 0, 1'b0, 24'h0);

        frame_pulse(100, 200, 1'b1, 1'b0);
        pixel("mirror63", 100, 201, 63, 1'b1, 24'hA5003F);
        pixel("mirror32", 131, 201, 32, 1'b1, 24'hA50020);

        for (int n = 1; n <= 25; n++) begin
            frame_pulse(100, 200, 1'b0, 1'b1);
            e = ((n - 1) / 6 % 3) * 1024;
            pixel($sformatf("anim%0d", n), 100, 200, e, 1'b1, {12'hA50, 12'(e)});
        end
        frame_pulse(100, 200, 1'b0, 1'b0);
        pixel("anim_stop", 100, 200, 0, 1'b1, 24'hA50000);
        frame_pulse(100, 200, 1'b0, 1'b1);
        pixel("anim_restart", 100, 200, 0, 1'b1, 24'hA50000);

        frame_pulse(620, 200, 1'b0, 1'b0);
        pixel("clip639", 639, 200, 19, 1'b1, 24'hA50013);
        pixel("clip619", 619, 200, 0, 1'b0, 24'h0);
        frame_pulse(1000, 200, 1'b0, 1'b0);
        pixel("nowrap0", 0, 200, 0, 1'b0, 24'h0);
        pixel("nowrap8", 8, 200, 0, 1'b0, 24'h0);

        frame_pulse(100, 200, 1'b0, 1'b0);
        force_en  = 1'b1;
        force_val = 24'hFF00FF;
        pixel("key", 100, 200, 0, 1'b0, 24'h0);
        force_val = 24'hFF00FE;
        pixel("nearkey", 100, 200, 0, 1'b1, 24'hFF00FE);
        force_en  = 1'b0;

        for (int n = 1; n <= 7; n++)
            frame_pulse(100, 200, 1'b0, 1'b1);
        pixel("pre_rst", 100, 200, 1024, 1'b1, 24'hA50400);
        Reset = 1'b1;
        step();
        check("mid_rst.on", 32'(sprite_on), 32'd0);
        check("mid_rst.pic", 32'(pic_out), 32'd0);
        check("mid_rst.addr", 32'(rom_addr), 32'd0);
        Reset = 1'b0;
        step();
        step();
        check("post_rst.on", 32'(sprite_on), 32'd0);
        check("post_rst.addr", 32'(rom_addr), 32'd0);
        frame_pulse(100, 200, 1'b0, 1'b1);
        pixel("post_rst_idle", 100, 200, 0, 1'b1, 24'hA50000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high; there are no other clock or reset inputs.
REQ-002 Clk  input  1  pixel clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 frame_clk  input  1  vertical-sync-derived frame pulse, sampled in the Clk domain.
REQ-005 DrawX, DrawY  input  10 each  current pixel coordinate.
REQ-006 sprite_x, sprite_y  input  10 each  top-left corner of the sprite, in screen pixels.
REQ-007 facing_left  input  1  when 1, the sprite is mirrored horizontally.
REQ-008 moving  input  1  when 1, the walk animation runs.
REQ-009 rom_addr  output  12  sprite ROM address; the ROM is synchronous with 1-cycle read latency.
REQ-010 rom_data  input  24  ROM pixel, RGB888, valid 1 cycle after rom_addr.
REQ-011 sprite_on  output  1  pixel is inside the sprite and opaque; drives the color mapper's sprite hit flag.
REQ-012 pic_out  output  24  sprite pixel; drives the color mapper's matching pic_out input.

Function
REQ-013 On a rising edge of frame_clk, detected by a 2-flop sample plus edge compare, the block SHALL latch sprite_x, sprite_y, facing_left and moving; all pixel logic uses only the latched copies, so the sprite never tears mid-frame.
REQ-014 In-box test, stage 0: computed with 11-bit unsigned arithmetic. in_box = (DrawX >= lx) && (DrawX < lx+W) && (DrawY >= ly) && (DrawY < ly+H); no wrap-around is permitted.
REQ-015 col = DrawX - lx and row = DrawY - ly; when latched facing_left = 1, col' = W-1-col, otherwise col' = col.
REQ-016 rom_addr SHALL be frame_idx*W*H + row*W + col', registered at the end of stage 0; when in_box = 0, rom_addr holds 0.
REQ-017 in_box SHALL be pipelined alongside the ROM read. At stage 2 (2 Clk cycles after DrawX/DrawY): sprite_on = in_box_d2 && (rom_data != KEY); pic_out = rom_data when sprite_on = 1, else 24'h000000.
REQ-018 Fixed latency from DrawX/DrawY to sprite_on/pic_out is 2 Clk cycles; the top level aligns its other color-mapper inputs to match.
REQ-019 Animation FSM states: IDLE and WALK; updates occur only on a detected frame edge.
REQ-020 IDLE: frame_idx = 0 and div_cnt = 0; moves to WALK on a frame edge with the newly latched moving = 1.
REQ-021 WALK: div_cnt increments each frame edge. At ANIM_DIV-1, div_cnt clears and frame_idx advances 0->1->2->0. On a frame edge with moving = 0, the FSM returns to IDLE and resets frame_idx and div_cnt.
REQ-022 A frame edge coinciding with an in-box pixel SHALL take effect for pixels entering stage 0 on the following cycle; pixels already in the pipeline complete with the old frame_idx.
REQ-023 The sprite SHALL render partially when it extends past x = 639 or y = 479 (the clip comes from the DrawX/DrawY range); no address is formed outside the box.

Reset
REQ-024 Reset SHALL clear: sprite_on = 0, pic_out = 0, rom_addr = 0, pipeline valid bits = 0, FSM = IDLE, frame_idx = 0, div_cnt = 0, edge-detect flops = 0, latched x = 0, facing = 0, moving = 0.
REQ-025 Reset SHALL set latched y = 10'd1023, so the sprite is invisible until the first frame edge.
REQ-026 Reset asserted mid-line SHALL force sprite_on = 0 on the next Clk edge; no stale pipeline pixel may appear after reset is released.

Structure
REQ-027 Package sprite_pkg SHALL hold: W = 32, H = 32, FRAMES = 3, ANIM_DIV = 6, KEY = 24'hFF00FF, the enum anim_state_t {IDLE, WALK}, and ADDR_W = 12.
REQ-028 The animation FSM, frame-edge detector and divider SHALL live in sub-module sprite_anim_fsm, which outputs frame_idx[1:0] and frame_edge.
REQ-029 The address generator and output pipeline SHALL be in sprite_fetch itself.

Verification
REQ-030 Reset, frame edge with sprite_x = 100, sprite_y = 200, facing_left = 0, then DrawX = 100, DrawY = 200 -> rom_addr = 0 one cycle later; sprite_on follows rom_data two cycles after the pixel.
REQ-031 facing_left = 1, DrawX = 100, DrawY = 201 -> rom_addr = 32+31 = 63.
REQ-032 moving = 1 for 18 frame edges -> frame_idx sequence 0 (6 edges), 1 (6), 2 (6), then 0; at frame_idx = 1, pixel (lx, ly) -> rom_addr = 1024.
REQ-033 sprite_x = 620, DrawX = 639 -> in_box = 1 with col 19; DrawX = 619 -> sprite_on = 0; sprite_x = 1000 never hits and shows no wrap.
REQ-034 rom_data = 24'hFF00FF inside the box -> sprite_on = 0, pic_out = 0; rom_data = 24'hFF00FE -> sprite_on = 1, pic_out = 24'hFF00FE.
REQ-035 Reset pulsed while streaming in-box pixels -> sprite_on = 0 from the next edge; the FSM is IDLE and the sprite stays hidden until the next frame edge.
